// File: rtl/layer_fetch_seq.sv
// Layer fetch sequencer: walks a frame in raster order, reads every enabled layer
// per pixel from the layer RAM and queues tagged words for the blend stage.
module layer_fetch_seq #(
  parameter int NUM_LAYERS = 8,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_enable,
  input  logic                  cfg_we,
  input  logic [5:0]            cfg_slot,
  input  logic [7:0]            cfg_layerId,
  input  logic [9:0]            cfg_width,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  pipe_read_en,
  output logic [5:0]            pipe_layer,
  output logic [7:0]            pipe_layerId,
  output logic [23:0]           pipe_addr_bytes,
  input  logic                  ram_rdy,
  input  logic [15:0]           ram_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_data,
  output logic [5:0]            out_slot,
  output logic [9:0]            out_x,
  output logic [8:0]            out_y,
  output logic                  out_last
);

  localparam int SW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 16 + 6 + 10 + 9 + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DATA, NEXT} state_t;

  state_t                state;
  logic [NUM_LAYERS-1:0] en;
  logic [5:0]            slot;
  logic [9:0]            x;
  logic [8:0]            y;
  logic [7:0]            tbl_id    [NUM_LAYERS];
  logic [9:0]            tbl_width [NUM_LAYERS];
  logic [SW-1:0]         si;

  logic                  hi_found;
  logic [5:0]            hi_slot, low_slot, start_slot;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  full, push, pop;

  assign si              = slot[SW-1:0];
  assign busy            = (state != IDLE);
  assign pipe_layer      = slot;
  assign pipe_layerId    = tbl_id[si];
  assign pipe_addr_bytes = ((24'(y) * 24'(tbl_width[si])) + 24'(x)) << 1;
  assign full            = (count == (PW+1)'(FIFO_DEPTH));
  assign pipe_read_en    = (state == ISSUE) && ram_rdy && !full;
  assign push            = (state == WAIT_DATA) && ram_rdy;
  assign out_valid       = (count != '0);
  assign pop             = out_valid && out_ready;
  assign {out_data, out_slot, out_x, out_y, out_last} = mem[rd_ptr];

  // Descending scan so the last hit is the lowest qualifying slot.
  always_comb begin
    hi_found   = 1'b0;
    hi_slot    = slot;
    low_slot   = '0;
    start_slot = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (en[i] && (i > int'(slot))) begin
        hi_found = 1'b1;
        hi_slot  = 6'(i);
      end
      if (en[i])           low_slot   = 6'(i);
      if (layer_enable[i]) start_slot = 6'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        tbl_id[i]    <= '0;
        tbl_width[i] <= '0;
      end
    end else if (cfg_we && !busy && ({26'd0, cfg_slot} < NUM_LAYERS)) begin
      tbl_id[cfg_slot[SW-1:0]]    <= cfg_layerId;
      tbl_width[cfg_slot[SW-1:0]] <= cfg_width;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      en         <= '0;
      slot       <= '0;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            en   <= layer_enable;
            x    <= '0;
            y    <= '0;
            slot <= start_slot;
            if (layer_enable == '0) frame_done <= 1'b1;
            else                    state      <= ISSUE;
          end
        end
        ISSUE:     if (pipe_read_en) state <= WAIT_BUSY;
        WAIT_BUSY: if (!ram_rdy)     state <= WAIT_DATA;
        WAIT_DATA: if (ram_rdy)      state <= NEXT;
        NEXT: begin
          state <= ISSUE;
          if (hi_found) begin
            slot <= hi_slot;
          end else begin
            slot <= low_slot;
            if (x == 10'(SCREEN_W - 1)) begin
              x <= '0;
              if (y == 9'(SCREEN_H - 1)) begin
                state      <= IDLE;
                frame_done <= 1'b1;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word storage needs no reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ram_read_data, slot, x, y, !hi_found};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_fetch_seq.sv
// Directed bench for layer_fetch_seq on a reduced 8x4 frame with a
// fixed-latency RAM model that returns the low 16 address bits as data.
module tb_layer_fetch_seq;

  logic        clk = 1'b0;
  logic        rst, start, cfg_we, out_ready;
  logic [7:0]  layer_enable, cfg_layerId;
  logic [5:0]  cfg_slot;
  logic [9:0]  cfg_width;
  logic        busy, frame_done, pipe_read_en, out_valid, out_last;
  logic [5:0]  pipe_layer, out_slot;
  logic [7:0]  pipe_layerId;
  logic [23:0] pipe_addr_bytes;
  logic        ram_rdy = 1'b1;
  logic [15:0] ram_read_data = '0;
  logic [15:0] out_data;
  logic [9:0]  out_x;
  logic [8:0]  out_y;

  int checks = 0;
  int errors = 0;
  int ram_cnt = 0;

  logic [31:0] req_addr[$], req_layer[$], req_id[$];
  logic [31:0] o_data[$], o_x[$], o_y[$], o_last[$];

  layer_fetch_seq #(.NUM_LAYERS(8), .SCREEN_W(8), .SCREEN_H(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_enable(layer_enable),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_layerId(cfg_layerId), .cfg_width(cfg_width),
    .busy(busy), .frame_done(frame_done), .pipe_read_en(pipe_read_en),
    .pipe_layer(pipe_layer), .pipe_layerId(pipe_layerId), .pipe_addr_bytes(pipe_addr_bytes),
    .ram_rdy(ram_rdy), .ram_read_data(ram_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_slot(out_slot),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // RAM: goes busy for 3 cycles after each accepted read.
  always @(posedge clk) begin
    if (pipe_read_en && ram_rdy) begin
      ram_rdy       <= 1'b0;
      ram_cnt       <= 3;
      ram_read_data <= pipe_addr_bytes[15:0];
      req_addr.push_back(32'(pipe_addr_bytes));
      req_layer.push_back(32'(pipe_layer));
      req_id.push_back(32'(pipe_layerId));
    end else if (ram_cnt > 1) begin
      ram_cnt <= ram_cnt - 1;
    end else if (ram_cnt == 1) begin
      ram_cnt <= 0;
      ram_rdy <= 1'b1;
    end
    if (!rst && out_valid && out_ready) begin
      o_data.push_back(32'(out_data));
      o_x.push_back(32'(out_x));
      o_y.push_back(32'(out_y));
      o_last.push_back(32'(out_last));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_cfg(input logic [5:0] s, input logic [7:0] id, input logic [9:0] w);
    cfg_we = 1'b1; cfg_slot = s; cfg_layerId = id; cfg_width = w;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] e);
    layer_enable = e; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    req_addr.delete(); req_layer.delete(); req_id.delete();
    o_data.delete(); o_x.delete(); o_y.delete(); o_last.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (frame_done) seen = 1'b1;
    end
    check({tag, " frame_done"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " busy at done"}, 32'(busy), 32'd0);
      tick(1);
      check({tag, " done one cycle"}, 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    int bad;
    bit seen;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    layer_enable = '0; cfg_slot = '0; cfg_layerId = '0; cfg_width = '0;
    tick(3);
    rst = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst read_en", 32'(pipe_read_en), 32'd0);
    check("rst addr", 32'(pipe_addr_bytes), 32'd0);
    check("rst layer/id", {18'd0, pipe_layer, pipe_layerId}, 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);

    // Empty enable: immediate frame_done, no reads.
    pulse_start(8'h00);
    check("empty frame_done", 32'(frame_done), 32'd1);
    check("empty busy", 32'(busy), 32'd0);
    tick(1);
    check("empty done pulse", 32'(frame_done), 32'd0);
    check("empty reads", 32'(req_addr.size()), 32'd0);

    // Single layer, slot 2, width 320; mid-frame start/enable changes ignored.
    do_cfg(6'd2, 8'h05, 10'd320);
    clear_logs();
    pulse_start(8'h04);
    tick(20);
    layer_enable = 8'hFF; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("A", 5000);
    check("A reads", 32'(req_addr.size()), 32'd32);
    check("A addr0", req_addr[0], 32'h0);
    check("A addr1", req_addr[1], 32'h2);
    check("A addr(5,1)", req_addr[13], 32'h28A);
    check("A id(5,1)", req_id[13], 32'h5);
    check("A layer(5,1)", req_layer[13], 32'h2);
    check("A words", 32'(o_data.size()), 32'd32);
    check("A data(5,1)", o_data[13], 32'h028A);
    check("A xy(5,1)", {o_x[13][15:0], o_y[13][15:0]}, {16'd5, 16'd1});
    check("A wrap xy", {o_x[8][15:0], o_y[8][15:0]}, {16'd0, 16'd1});
    check("A final xy", {o_x[31][15:0], o_y[31][15:0]}, {16'd7, 16'd3});
    check("A last", o_last[0], 32'd1);

    // Two layers: slot 0 (width 320) then slot 3 (width 64) per pixel.
    do_cfg(6'd0, 8'h01, 10'd320);
    do_cfg(6'd3, 8'h03, 10'd64);
    clear_logs();
    pulse_start(8'h09);
    wait_done("B", 5000);
    check("B reads", 32'(req_addr.size()), 32'd64);
    check("B layer first", req_layer[0], 32'd0);
    check("B layer second", req_layer[1], 32'd3);
    check("B last first", o_last[0], 32'd0);
    check("B last second", o_last[1], 32'd1);
    check("B slot0 (0,1) addr", req_addr[16], 32'h280);
    check("B slot3 (0,1) addr", req_addr[17], 32'h80);
    check("B slot3 id", req_id[17], 32'h3);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (req_layer[i] !== ((i % 2 == 1) ? 32'd3 : 32'd0)) bad++;
      if (o_last[i] !== ((i % 2 == 1) ? 32'd1 : 32'd0)) bad++;
    end
    check("B order", 32'(bad), 32'd0);

    // Backpressure: FIFO fills with 4 words then issue stalls.
    clear_logs();
    out_ready = 1'b0;
    pulse_start(8'h04);
    tick(100);
    check("C reads stalled", 32'(req_addr.size()), 32'd4);
    check("C out_valid", 32'(out_valid), 32'd1);
    check("C read_en", 32'(pipe_read_en), 32'd0);
    tick(50);
    check("C still stalled", 32'(req_addr.size()), 32'd4);
    out_ready = 1'b1;
    wait_done("C", 5000);
    check("C words", 32'(o_data.size()), 32'd32);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (o_data[i] !== 32'(((i / 8) * 320 + (i % 8)) * 2)) bad++;
    check("C stream order", 32'(bad), 32'd0);

    // Reset while waiting on the second read's data.
    clear_logs();
    out_ready = 1'b0;
    pulse_start(8'h04);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick(1);
      if (req_addr.size() == 2) seen = 1'b1;
    end
    check("D reached read 2", 32'(seen), 32'd1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    out_ready = 1'b1;
    check("D busy", 32'(busy), 32'd0);
    check("D out_valid", 32'(out_valid), 32'd0);
    check("D read_en", 32'(pipe_read_en), 32'd0);
    for (int i = 0; i < 20 && !ram_rdy; i++) tick(1);
    tick(2);
    check("D dropped word", 32'(out_valid), 32'd0);
    check("D table cleared", 32'(pipe_layerId), 32'd0);
    do_cfg(6'd2, 8'h05, 10'd320);
    clear_logs();
    pulse_start(8'h04);
    wait_done("D", 5000);
    check("D restart addr", req_addr[0], 32'h0);
    check("D restart xy", {o_x[0][15:0], o_y[0][15:0]}, 32'd0);
    check("D restart words", 32'(o_data.size()), 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
